// File: rtl/usb_receiver.sv
// Full-speed USB packet receiver: line synchronizers, edge-locked bit clock,
// NRZI decode, bit unstuffing, SYNC/PID/CRC16 checks and delayed FIFO writes.
module usb_receiver #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       full,
  output logic [7:0] rcv_data,
  output logic       w_enable,
  output logic       rcving,
  output logic       pkt_good,
  output logic       pkt_bad,
  output logic       r_error
);

  localparam int unsigned   CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] SAMPLE_AT    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    SYNC_BYTE    = 8'h80;
  localparam logic [7:0]    PID_DATA0    = 8'hC3;
  localparam logic [7:0]    PID_DATA1    = 8'h4B;
  localparam logic [15:0]   CRC_INIT     = 16'hFFFF;
  localparam logic [15:0]   CRC_POLY     = 16'h8005;
  localparam logic [15:0]   CRC_RESIDUAL = 16'h800D;

  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, EOP, ERR} state_t;

  // synchronizer and edge-detect registers
  logic dp_s1, dp_s2, dm_s1, dm_s2, dp_d, dm_d;

  // bit clock
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] cnt_eff;
  logic          dp_edge;
  logic          strobe;

  // packet state and datapath
  state_t      state, state_nx;
  logic        prev_dp, prev_dp_nx;
  logic [2:0]  ones, ones_nx;
  logic [7:0]  shreg, shreg_nx;
  logic [2:0]  bitpos, bitpos_nx;
  logic [15:0] crc, crc_nx;
  logic [7:0]  hold0, hold0_nx;
  logic [7:0]  hold1, hold1_nx;
  logic [1:0]  hold_cnt, hold_cnt_nx;
  logic        eop_good, eop_good_nx;
  logic        err_se0, err_se0_nx;
  logic [7:0]  rcv_data_nx;
  logic        w_enable_nx, rcving_nx, pkt_good_nx, pkt_bad_nx, r_error_nx;

  // derived per-sample values
  logic        line_se0, line_j, nrzi_bit, start, pid_ok, crc_fb;
  logic [7:0]  new_byte;
  logic [15:0] crc_step;

  // two-flop synchronizers, reset to idle J, plus one more stage for edge detection
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_s1 <= 1'b1;
      dp_s2 <= 1'b1;
      dp_d  <= 1'b1;
      dm_s1 <= 1'b0;
      dm_s2 <= 1'b0;
      dm_d  <= 1'b0;
    end else begin
      dp_s1 <= d_plus;
      dp_s2 <= dp_s1;
      dp_d  <= dp_s2;
      dm_s1 <= d_minus;
      dm_s2 <= dm_s1;
      dm_d  <= dm_s2;
    end
  end

  // the cycle in which D+ changes counts as bit-clock phase zero
  assign dp_edge = dp_s2 ^ dp_d;
  assign cnt_eff = dp_edge ? '0 : bit_cnt;
  assign strobe  = (cnt_eff == SAMPLE_AT);

  // free-running bit-phase counter, re-aligned on every D+ transition
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt <= '0;
    end else if (cnt_eff == CNT_LAST) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= cnt_eff + CW'(1);
    end
  end

  // D- must have been low just before D+ fell, i.e. the bus left idle J
  assign start    = dp_d & ~dp_s2 & ~dm_d;
  assign line_se0 = (dp_s2 == dm_s2);
  assign line_j   = dp_s2 & ~dm_s2;
  assign nrzi_bit = (dp_s2 == prev_dp);
  assign new_byte = {nrzi_bit, shreg[7:1]};
  assign pid_ok   = (new_byte[3:0] == ~new_byte[7:4]) &&
                    ((new_byte == PID_DATA0) || (new_byte == PID_DATA1));
  assign crc_fb   = nrzi_bit ^ crc[15];
  assign crc_step = {crc[14:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);

  // packet FSM next-state, datapath updates and registered-output next values
  always_comb begin
    state_nx    = state;
    prev_dp_nx  = prev_dp;
    ones_nx     = ones;
    shreg_nx    = shreg;
    bitpos_nx   = bitpos;
    crc_nx      = crc;
    hold0_nx    = hold0;
    hold1_nx    = hold1;
    hold_cnt_nx = hold_cnt;
    eop_good_nx = eop_good;
    err_se0_nx  = err_se0;
    rcv_data_nx = rcv_data;
    w_enable_nx = 1'b0;
    rcving_nx   = rcving;
    pkt_good_nx = 1'b0;
    pkt_bad_nx  = 1'b0;
    r_error_nx  = r_error;

    case (state)
      IDLE: begin
        if (start) begin
          state_nx    = SYNC;
          rcving_nx   = 1'b1;
          r_error_nx  = 1'b0;
          prev_dp_nx  = 1'b1;
          ones_nx     = '0;
          bitpos_nx   = '0;
          hold_cnt_nx = '0;
          err_se0_nx  = 1'b0;
        end
      end

      SYNC, PID, DATA: begin
        if (strobe) begin
          if (line_se0) begin
            if (state == DATA) begin
              state_nx    = EOP;
              eop_good_nx = (bitpos == 3'd0) && (hold_cnt == 2'd2) && (crc == CRC_RESIDUAL);
            end else begin
              state_nx   = ERR;
              err_se0_nx = 1'b1;
              r_error_nx = 1'b1;
            end
          end else begin
            prev_dp_nx = dp_s2;
            if (ones == 3'd6) begin
              // stuffed bit: discarded, must decode as 0
              ones_nx = '0;
              if (nrzi_bit) begin
                state_nx   = ERR;
                r_error_nx = 1'b1;
              end
            end else begin
              ones_nx   = nrzi_bit ? ones + 3'd1 : '0;
              shreg_nx  = new_byte;
              bitpos_nx = bitpos + 3'd1;
              if (state == DATA) begin
                crc_nx = crc_step;
              end
              if (bitpos == 3'd7) begin
                case (state)
                  SYNC: begin
                    if (new_byte == SYNC_BYTE) begin
                      state_nx = PID;
                    end else begin
                      state_nx   = ERR;
                      r_error_nx = 1'b1;
                    end
                  end
                  PID: begin
                    if (pid_ok) begin
                      state_nx    = DATA;
                      crc_nx      = CRC_INIT;
                      hold_cnt_nx = '0;
                    end else begin
                      state_nx   = ERR;
                      r_error_nx = 1'b1;
                    end
                  end
                  default: begin
                    // the two newest bytes are held back so CRC bytes never reach the FIFO
                    if (hold_cnt == 2'd2) begin
                      if (full) begin
                        state_nx   = ERR;
                        r_error_nx = 1'b1;
                      end else begin
                        w_enable_nx = 1'b1;
                        rcv_data_nx = hold0;
                      end
                      hold0_nx = hold1;
                      hold1_nx = new_byte;
                    end else if (hold_cnt == 2'd1) begin
                      hold1_nx    = new_byte;
                      hold_cnt_nx = 2'd2;
                    end else begin
                      hold0_nx    = new_byte;
                      hold_cnt_nx = 2'd1;
                    end
                  end
                endcase
              end
            end
          end
        end
      end

      EOP: begin
        if (strobe && line_j) begin
          state_nx    = IDLE;
          rcving_nx   = 1'b0;
          pkt_good_nx = eop_good;
          pkt_bad_nx  = ~eop_good;
          r_error_nx  = r_error | ~eop_good;
        end
      end

      ERR: begin
        if (strobe) begin
          if (line_se0) begin
            err_se0_nx = 1'b1;
          end else if (line_j && err_se0) begin
            state_nx   = IDLE;
            rcving_nx  = 1'b0;
            pkt_bad_nx = 1'b1;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // packet state, datapath and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      prev_dp  <= 1'b1;
      ones     <= '0;
      shreg    <= '0;
      bitpos   <= '0;
      crc      <= CRC_INIT;
      hold0    <= '0;
      hold1    <= '0;
      hold_cnt <= '0;
      eop_good <= 1'b0;
      err_se0  <= 1'b0;
      rcv_data <= '0;
      w_enable <= 1'b0;
      rcving   <= 1'b0;
      pkt_good <= 1'b0;
      pkt_bad  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      state    <= state_nx;
      prev_dp  <= prev_dp_nx;
      ones     <= ones_nx;
      shreg    <= shreg_nx;
      bitpos   <= bitpos_nx;
      crc      <= crc_nx;
      hold0    <= hold0_nx;
      hold1    <= hold1_nx;
      hold_cnt <= hold_cnt_nx;
      eop_good <= eop_good_nx;
      err_se0  <= err_se0_nx;
      rcv_data <= rcv_data_nx;
      w_enable <= w_enable_nx;
      rcving   <= rcving_nx;
      pkt_good <= pkt_good_nx;
      pkt_bad  <= pkt_bad_nx;
      r_error  <= r_error_nx;
    end
  end

endmodule

// File: tb/tb_usb_receiver.sv
// Scoreboard bench for usb_receiver: packets are built from byte lists,
// CRC'd, stuffed and NRZI-encoded by the bench; a monitor checks every
// FIFO write and status pulse against queued expectations.
module tb_usb_receiver;

  localparam int unsigned CPB = 8;
  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_plus = 1'b1;
  logic       d_minus = 1'b0;
  logic       full = 1'b0;
  logic [7:0] rcv_data;
  logic       w_enable, rcving, pkt_good, pkt_bad, r_error;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_bytes[$];
  bit         exp_status[$];
  logic [7:0] pkt_data[$];

  usb_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .d_plus   (d_plus),
    .d_minus  (d_minus),
    .full     (full),
    .rcv_data (rcv_data),
    .w_enable (w_enable),
    .rcving   (rcving),
    .pkt_good (pkt_good),
    .pkt_bad  (pkt_bad),
    .r_error  (r_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every write and status pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (n_rst) begin
      if (w_enable) begin
        check("write_expected", int'(exp_bytes.size() != 0), 1);
        if (exp_bytes.size() != 0) check("rcv_data", int'(rcv_data), int'(exp_bytes.pop_front()));
      end
      if (pkt_good || pkt_bad) begin
        check("status_expected", int'(exp_status.size() != 0), 1);
        if (exp_status.size() != 0) begin
          bit eg;
          eg = exp_status.pop_front();
          check("pkt_good", int'(pkt_good), int'(eg));
          check("pkt_bad", int'(pkt_bad), int'(!eg));
          check("r_error_at_end", int'(r_error), int'(!eg));
          check("rcving_at_end", int'(rcving), 0);
          check("write_with_status", int'(w_enable), 0);
        end
      end
    end
  end

  task automatic line(input logic [1:0] v);
    {d_plus, d_minus} = v;
    repeat (CPB) @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rcv_data"}, int'(rcv_data), 0);
    check({tag, "_w_enable"}, int'(w_enable), 0);
    check({tag, "_rcving"},   int'(rcving), 0);
    check({tag, "_pkt_good"}, int'(pkt_good), 0);
    check({tag, "_pkt_bad"},  int'(pkt_bad), 0);
    check({tag, "_r_error"},  int'(r_error), 0);
  endtask

  // sends SYNC byte s, PID p, pkt_data and CRC; abort_at >= 0 resets the DUT at that line bit
  task automatic run_packet(input logic [7:0] s, input logic [7:0] p, input bit flip,
                            input bit viol, input bit fullv, input int abort_at);
    bit         lb[$];
    logic [1:0] lv[$];
    logic [15:0] c;
    logic [15:0] tx;
    int  ones, cdone, n, nw, w;
    bit  lvl, viol_done, sb, hdr_ok, fb;
    n = pkt_data.size();
    for (int k = 0; k < 8; k++) lb.push_back(s[k]);
    for (int k = 0; k < 8; k++) lb.push_back(p[k]);
    c = 16'hFFFF;
    for (int b = 0; b < n; b++) begin
      logic [7:0] byt;
      byt = pkt_data[b];
      for (int k = 0; k < 8; k++) begin
        lb.push_back(byt[k]);
        fb = byt[k] ^ c[15];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    tx = ~c;
    for (int k = 15; k >= 0; k--) lb.push_back(tx[k]);
    if (flip) begin
      int pos;
      pos = lb.size() - 1 - int'($urandom_range(0, 7));
      lb[pos] = ~lb[pos];
    end
    // stuff after six 1s, then NRZI (0 toggles the line, 1 holds it)
    lvl = 1'b1; ones = 0; viol_done = 0; cdone = 0;
    for (int i = 0; i < lb.size(); i++) begin
      if (!lb[i]) lvl = ~lvl;
      lv.push_back(lvl ? LJ : LK);
      ones = lb[i] ? ones + 1 : 0;
      if (ones == 6) begin
        sb = viol && !viol_done && (i >= 16);
        if (sb) begin
          viol_done = 1;
          cdone = (i + 1 - 16) / 8;
        end
        if (!sb) lvl = ~lvl;
        lv.push_back(lvl ? LJ : LK);
        ones = 0;
      end
    end
    // expectation from the packet-level rules
    hdr_ok = (s == 8'h80) && ((p == 8'hC3) || (p == 8'h4B));
    if (abort_at < 0) begin
      if (!hdr_ok) begin
        exp_status.push_back(1'b0);
      end else if (viol_done) begin
        nw = (cdone > 2) ? cdone - 2 : 0;
        if (nw > n) nw = n;
        for (int k = 0; k < nw; k++) exp_bytes.push_back(pkt_data[k]);
        exp_status.push_back(1'b0);
      end else if (fullv && n > 0) begin
        exp_status.push_back(1'b0);
      end else begin
        for (int k = 0; k < n; k++) exp_bytes.push_back(pkt_data[k]);
        exp_status.push_back(!flip);
      end
    end
    full = fullv;
    for (int i = 0; i < lv.size(); i++) begin
      if (i == abort_at) begin
        check("rcving_before_reset", int'(rcving), 1);
        n_rst = 1'b0;
        {d_plus, d_minus} = LJ;
        #1;
        check_reset_outputs("midreset");
        full = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_rst = 1'b1;
        repeat (4) line(LJ);
        return;
      end
      if (i == 10) check("rcving_mid_packet", int'(rcving), 1);
      line(lv[i]);
    end
    line(LSE0);
    line(LSE0);
    line(LJ);
    w = 0;
    while (exp_status.size() != 0 && w < 600) begin
      @(posedge clk);
      w++;
    end
    #2;
    check("status_seen_in_time", int'(exp_status.size() == 0), 1);
    check("writes_outstanding", exp_bytes.size(), 0);
    exp_status.delete();
    exp_bytes.delete();
    full = 1'b0;
    repeat (3 + $urandom_range(0, 3)) line(LJ);
  endtask

  initial begin
    int kind, len;
    logic [7:0] s, p;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    repeat (3) line(LJ);

    pkt_data = {};
    run_packet(8'h80, 8'hC3, 0, 0, 0, -1);                  // zero-length
    pkt_data = {8'hFF, 8'hFF, 8'h01};
    run_packet(8'h80, 8'h4B, 0, 0, 0, -1);                  // stuffed data
    run_packet(8'h80, 8'h4B, 0, 1, 0, -1);                  // stuff violation
    run_packet(8'h80, 8'h4B, 1, 0, 0, -1);                  // corrupted CRC
    run_packet(8'h80, 8'hC4, 0, 0, 0, -1);                  // bad PID
    run_packet(8'h40, 8'hC3, 0, 0, 0, -1);                  // bad SYNC
    run_packet(8'h80, 8'hC3, 0, 0, 1, -1);                  // overflow
    pkt_data = {};
    run_packet(8'h80, 8'h4B, 0, 0, 1, -1);                  // full but no write due
    pkt_data = {8'h12, 8'h34, 8'h56, 8'h78};
    run_packet(8'h80, 8'hC3, 0, 0, 0, 20);                  // reset mid-DATA
    pkt_data = {8'hA5, 8'h5A, 8'h3C};
    run_packet(8'h80, 8'hC3, 0, 0, 0, -1);                  // recovery

    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 9));
      len  = int'($urandom_range(0, 6));
      pkt_data = {};
      for (int k = 0; k < len; k++)
        pkt_data.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
      s = 8'h80;
      p = ($urandom_range(0, 1) == 0) ? 8'hC3 : 8'h4B;
      if (kind == 7) begin
        p = 8'($urandom_range(0, 255));
        if (p == 8'hC3 || p == 8'h4B) p = 8'hC4;
      end
      if (kind == 8) begin
        s = 8'($urandom_range(0, 255)) & 8'hFE;
        if (s == 8'h80) s = 8'h40;
      end
      run_packet(s, p, kind == 5, kind == 6, kind == 9, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
